// File: rtl/lif_group.sv
// Group of eight leaky integrate-and-fire neurons sharing one weight-memory sweep per timestep.
// Optional build macro LIF_REFRACT_EN: a neuron that fired skips accumulation for the next timestep.
module lif_group #(
   parameter int V_WIDTH     = 10,
   parameter int THRESH      = 64,
   parameter int DECAY_SHIFT = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] spike_in,
   input  logic [3:0]  weight_1,
   input  logic [3:0]  weight_2,
   input  logic [3:0]  weight_3,
   input  logic [3:0]  weight_4,
   input  logic [3:0]  weight_5,
   input  logic [3:0]  weight_6,
   input  logic [3:0]  weight_7,
   input  logic [3:0]  weight_8,
   output logic [4:0]  addr,
   output logic        syn_en,
   output logic [7:0]  spike_out,
   output logic        busy,
   output logic        done
);

   // state      | meaning
   // IDLE       | waiting for start
   // SET        | latch spike_in, clear cnt
   // SYN_ACCU   | sweep rows 0..31, accumulate weights two cycles behind addr
   // DECAY      | V -= V >> DECAY_SHIFT
   // FIRE       | threshold compare, reset fired neurons, load spike_out
   // DONE       | one-cycle done pulse
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SET      = 3'd1,
      SYN_ACCU = 3'd2,
      DECAY    = 3'd3,
      FIRE     = 3'd4,
      DONE     = 3'd5
   } state_t;

   localparam logic [V_WIDTH:0]   THR   = (V_WIDTH+1)'(THRESH);
   localparam logic [V_WIDTH-1:0] V_MAX = '1;

   state_t                    state, state_nxt;
   logic [5:0]                cnt;
   logic [31:0]               spike_reg;
   logic                      acc_d1, acc_d2;
   logic [7:0][V_WIDTH-1:0]   v, v_nxt;
   logic [7:0][3:0]           weight;
   logic [7:0]                fire_vec;
   logic [7:0]                refr;

   assign weight[0] = weight_1;
   assign weight[1] = weight_2;
   assign weight[2] = weight_3;
   assign weight[3] = weight_4;
   assign weight[4] = weight_5;
   assign weight[5] = weight_6;
   assign weight[6] = weight_7;
   assign weight[7] = weight_8;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      syn_en    = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      addr      = 5'd0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = SET;
         end
         SET:      state_nxt = SYN_ACCU;
         SYN_ACCU: begin
            syn_en = 1'b1;
            addr   = cnt[5] ? 5'd31 : cnt[4:0];
            if (cnt == 6'd33) state_nxt = DECAY;
         end
         DECAY:    state_nxt = FIRE;
         FIRE:     state_nxt = DONE;
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            busy      = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      logic [V_WIDTH:0] sum;
      v_nxt    = v;
      fire_vec = '0;
      sum      = '0;
      for (int k = 0; k < 8; k++) begin
         fire_vec[k] = ({1'b0, v[k]} >= THR);
         sum = {1'b0, v[k]} + {{(V_WIDTH-3){1'b0}}, weight[k]};
         case (state)
            SYN_ACCU: if (acc_d2 && !refr[k]) v_nxt[k] = sum[V_WIDTH] ? V_MAX : sum[V_WIDTH-1:0];
            DECAY:    v_nxt[k] = v[k] - (v[k] >> DECAY_SHIFT);
            FIRE:     if (fire_vec[k]) v_nxt[k] = '0;
            default:  v_nxt[k] = v[k];
         endcase
      end
   end

   // acc_d1/acc_d2 delay spike_reg[row] to line up with the two-cycle weight latency.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt       <= '0;
         spike_reg <= '0;
         acc_d1    <= 1'b0;
         acc_d2    <= 1'b0;
         v         <= '0;
         spike_out <= '0;
      end else begin
         acc_d1 <= (state == SYN_ACCU) && !cnt[5] && spike_reg[cnt[4:0]];
         acc_d2 <= acc_d1;
         v      <= v_nxt;
         if (state == SET) begin
            spike_reg <= spike_in;
            cnt       <= '0;
         end else if (state == SYN_ACCU) begin
            cnt <= cnt + 6'd1;
         end
         if (state == FIRE) spike_out <= fire_vec;
      end
   end

`ifdef LIF_REFRACT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)               refr <= '0;
      else if (state == FIRE) refr <= fire_vec;
   end
`else
   assign refr = '0;
`endif

endmodule

// File: tb/tb_lif_group.sv
// Bench for lif_group: registered weight-memory model, per-timestep reference model and spike scoreboard.
module tb_lif_group;

   logic        clk, rst;
   logic        start_a, start_b;
   logic [31:0] spike_in;
   logic [4:0]  addr_a, addr_b;
   logic        syn_en_a, syn_en_b, busy_a, busy_b, done_a, done_b;
   logic [7:0]  spike_out_a, spike_out_b;
   logic [31:0] mem_a_q, mem_b_q, w_a, w_b;
   logic [31:0] rows [32];
   logic [7:0][9:0] v_a, v_b;

   int checks = 0;
   int errors = 0;

   int          mv [2][8];
   logic [7:0]  mrefr [2];
   int          ea [8], ed [8], ef [8];
   logic [7:0]  spk_q [$];

   lif_group dut_a (
      .clk(clk), .rst(rst), .start(start_a), .spike_in(spike_in),
      .weight_1(w_a[31:28]), .weight_2(w_a[27:24]), .weight_3(w_a[23:20]), .weight_4(w_a[19:16]),
      .weight_5(w_a[15:12]), .weight_6(w_a[11:8]),  .weight_7(w_a[7:4]),   .weight_8(w_a[3:0]),
      .addr(addr_a), .syn_en(syn_en_a), .spike_out(spike_out_a), .busy(busy_a), .done(done_a)
   );

   lif_group #(.THRESH(1023)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .spike_in(spike_in),
      .weight_1(w_b[31:28]), .weight_2(w_b[27:24]), .weight_3(w_b[23:20]), .weight_4(w_b[19:16]),
      .weight_5(w_b[15:12]), .weight_6(w_b[11:8]),  .weight_7(w_b[7:4]),   .weight_8(w_b[3:0]),
      .addr(addr_b), .syn_en(syn_en_b), .spike_out(spike_out_b), .busy(busy_b), .done(done_b)
   );

   assign v_a = dut_a.v;
   assign v_b = dut_b.v;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One-cycle memory read followed by the synapse register, which outputs 0 while syn_en is low.
   always @(posedge clk) begin
      mem_a_q <= rows[addr_a];
      mem_b_q <= rows[addr_b];
      w_a     <= syn_en_a ? mem_a_q : 32'd0;
      w_b     <= syn_en_b ? mem_b_q : 32'd0;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_ts(input int b, input logic [31:0] sin);
      int thr, acc, d, skip;
      logic [31:0] row;
      logic [7:0] spk;
      thr = (b == 1) ? 1023 : 64;
      spk = '0;
      for (int k = 0; k < 8; k++) begin
         acc  = mv[b][k];
         skip = 0;
`ifdef LIF_REFRACT_EN
         skip = mrefr[b][k] ? 1 : 0;
`endif
         if (skip == 0)
            for (int r = 0; r < 32; r++)
               if (sin[r]) begin
                  row = rows[r];
                  acc = acc + int'(row[31-4*k -: 4]);
                  if (acc > 1023) acc = 1023;
               end
         ea[k] = acc;
         d = acc - (acc >> 3);
         ed[k] = d;
         spk[k] = (d >= thr);
         ef[k] = spk[k] ? 0 : d;
         mv[b][k] = ef[k];
      end
      mrefr[b] = spk;
      spk_q.push_back(spk);
   endtask

   task automatic run_ts(input int b, input logic [31:0] sin, input bit restart5);
      int dn, dcyc, prev, vcur;
      bit wrapped;
      logic [7:0] espk;
      logic [7:0][9:0] vv;
      model_ts(b, sin);
      @(negedge clk);
      spike_in = sin;
      if (b == 1) start_b = 1'b1; else start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0; start_b = 1'b0;
      check("busy_after_start", (b == 1) ? busy_b : busy_a, 1);
      dn = 0; dcyc = 0; prev = 0; wrapped = 0;
      for (int cyc = 2; cyc <= 45; cyc++) begin
         @(posedge clk); #1;
         if (restart5 && cyc == 5) begin
            if (b == 1) start_b = 1'b1; else start_a = 1'b1;
         end
         if (cyc == 6) begin start_a = 1'b0; start_b = 1'b0; end
         vv = (b == 1) ? v_b : v_a;
         vcur = int'(vv[0]);
         if (cyc <= 36 && vcur < prev) wrapped = 1;
         prev = vcur;
         if (cyc == 36) for (int k = 0; k < 8; k++) check($sformatf("v_acc_%0d", k+1), vv[k], ea[k]);
         if (cyc == 37) for (int k = 0; k < 8; k++) check($sformatf("v_decay_%0d", k+1), vv[k], ed[k]);
         if ((b == 1) ? done_b : done_a) begin
            dn++;
            if (dn == 1) begin
               dcyc = cyc;
               espk = spk_q.pop_front();
               check("spike_out", (b == 1) ? spike_out_b : spike_out_a, espk);
            end
         end
      end
      if (dn == 0 && spk_q.size() > 0) espk = spk_q.pop_front();
      check("done_count", dn, 1);
      check("done_cycle", dcyc, 38);
      check("no_wrap", wrapped, 0);
      vv = (b == 1) ? v_b : v_a;
      for (int k = 0; k < 8; k++) check($sformatf("v_final_%0d", k+1), vv[k], ef[k]);
   endtask

   initial begin
      int dn;
      rst = 1'b0; start_a = 1'b0; start_b = 1'b0; spike_in = '0;
      for (int r = 0; r < 32; r++) rows[r] = '0;
      for (int b = 0; b < 2; b++) begin
         mrefr[b] = '0;
         for (int k = 0; k < 8; k++) mv[b][k] = 0;
      end
      repeat (3) @(negedge clk);
      check("rst_busy", busy_a, 0);
      check("rst_done", done_a, 0);
      check("rst_syn_en", syn_en_a, 0);
      check("rst_addr", addr_a, 0);
      check("rst_spike_out", spike_out_a, 0);
      check("rst_spike_out_b", spike_out_b, 0);
      rst = 1'b1;

      // Full weights, all inputs: 480 -> 420, every neuron fires; repeated for refractory behaviour.
      for (int r = 0; r < 32; r++) rows[r] = 32'hFFFF_FFFF;
      run_ts(0, 32'hFFFF_FFFF, 0);
      run_ts(0, 32'hFFFF_FFFF, 0);

      // Single row, single neuron weight.
      for (int r = 0; r < 32; r++) rows[r] = '0;
      rows[0] = 32'h5000_0000;
      run_ts(0, 32'h0000_0001, 0);

      // start re-asserted while busy must be ignored.
      for (int r = 0; r < 32; r++) rows[r] = 32'hFFFF_FFFF;
      run_ts(0, 32'hFFFF_FFFF, 1);

      for (int r = 0; r < 32; r++) rows[r] = $urandom;
      run_ts(0, $urandom, 0);

      // Reset asserted at cnt = 10 aborts the timestep.
      @(negedge clk);
      spike_in = 32'hFFFF_FFFF; start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      check("mid_addr_before_rst", addr_a, 10);
      rst = 1'b0;
      #1;
      check("mid_rst_busy", busy_a, 0);
      check("mid_rst_syn_en", syn_en_a, 0);
      check("mid_rst_addr", addr_a, 0);
      check("mid_rst_done", done_a, 0);
      check("mid_rst_spike_out", spike_out_a, 0);
      for (int k = 0; k < 8; k++) check($sformatf("mid_rst_v_%0d", k+1), v_a[k], 0);
      for (int b = 0; b < 2; b++) begin
         mrefr[b] = '0;
         for (int k = 0; k < 8; k++) mv[b][k] = 0;
      end
      @(negedge clk);
      rst = 1'b1;
      dn = 0;
      for (int i = 0; i < 45; i++) begin
         @(posedge clk); #1;
         if (done_a) dn++;
      end
      check("no_done_after_abort", dn, 0);

      // High threshold instance: potential climbs to saturation at 1023 without wrapping.
      for (int r = 0; r < 32; r++) rows[r] = 32'hFFFF_FFFF;
      run_ts(1, 32'hFFFF_FFFF, 0);
      run_ts(1, 32'hFFFF_FFFF, 0);
      run_ts(1, 32'hFFFF_FFFF, 0);
      check("sat_peak_model", ea[0], 1023);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
